// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register addresses are 4 bits; the flush counter covers FLUSH_CYCLES up to 7.
package hazard_ctrl_pkg;
    localparam int REG_ADDR_W       = 4;
    localparam int DEF_NREG         = 16;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int CNT_W            = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/hz_scoreboard.sv
// Register write-pending scoreboard: one busy bit per architectural register.
// Set wins over clear on the same bit; R0 is never tracked.
module hz_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG = DEF_NREG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        set_en,
    input  logic [REG_ADDR_W-1:0]       set_addr,
    input  logic                        clr_en,
    input  logic [REG_ADDR_W-1:0]       clr_addr,
    input  logic [2:0][REG_ADDR_W-1:0]  rd_addr,
    output logic [2:0]                  rd_busy,
    output logic [NREG-1:0]             mask
);
    logic [NREG-1:0] mask_q;
    logic [NREG-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        for (int i = 1; i < NREG; i++) begin
            if (clr_en && clr_addr == REG_ADDR_W'(i)) mask_d[i] = 1'b0;
            if (set_en && set_addr == REG_ADDR_W'(i)) mask_d[i] = 1'b1;
        end
        mask_d[0] = 1'b0;
    end

    // Reads see only the registered mask, so a clear never bypasses into this cycle.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREG; i++) begin
                if (rd_addr[k] == REG_ADDR_W'(i)) rd_busy[k] = mask_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else        mask_q <= mask_d;
    end

    assign mask = mask_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush control for a simple in-order pipeline: scoreboard-based
// RAW/WAW interlock plus a fixed-length flush after a taken branch in EXE.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG         = DEF_NREG,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_needs_wb,
    input  logic                  exe_is_branch,
    input  logic                  exe_z_flag,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  issue,
    output logic                  stall,
    output logic                  flush,
    output logic                  pc_sel,
    output logic [NREG-1:0]       busy_mask
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken;
    logic             hazard;
    logic [2:0]       src_busy;
    logic             set_en;

    hz_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (dec_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .rd_addr  ({dec_rd, dec_rs2, dec_rs1}),
        .rd_busy  (src_busy),
        .mask     (busy_mask)
    );

    assign taken  = exe_is_branch & exe_z_flag;
    assign hazard = (dec_uses_rs1 & src_busy[0])
                  | (dec_uses_rs2 & src_busy[1])
                  | (dec_needs_wb & src_busy[2]);
    assign set_en = issue & dec_needs_wb & (dec_rd != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        pc_sel  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    pc_sel  = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    issue = dec_valid & ~hazard;
                    stall = dec_valid & hazard;
                end
            end
            ST_FLUSH: begin
                // Bubbles hold no branches, so taken is deliberately ignored here.
                flush = 1'b1;
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter NREG, default 16, giving the number of architectural registers (4-bit address).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of bubble cycles after a taken branch (legal range 1..7).
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dec_valid  in  1  DEC holds an instruction.
- dec_rs1 / dec_rs2  in  4  source register addresses.
- dec_uses_rs1 / dec_uses_rs2  in  1  source actually read.
- dec_rd  in  4  destination address.
- dec_needs_wb  in  1  instruction writes RF.
- exe_is_branch  in  1  EXE holds a branch.
- exe_z_flag  in  1  branch condition true.
- wb_valid  in  1  WB retiring a register write.
- wb_addr  in  4  WB destination.
- issue  out  1  DEC→EXE transfer this cycle.
- stall  out  1  hold PC and DEC.
- flush  out  1  kill fetch/DEC contents.
- pc_sel  out  1  1 = load branch target (EXE pc_out).
- busy_mask  out  NREG  scoreboard, bit i = write to Ri pending.

Function
REQ-004 taken SHALL equal exe_is_branch & exe_z_flag, combinationally.
REQ-005 hazard SHALL be asserted when any of the following holds against the registered busy_mask: (dec_uses_rs1 & busy[rs1]), (dec_uses_rs2 & busy[rs2]), or (dec_needs_wb & busy[rd]) (WAW).
REQ-006 FSM states SHALL be RUN and FLUSH; reset state is RUN.
REQ-007 In RUN: issue = dec_valid & ~hazard & ~taken; stall = dec_valid & hazard & ~taken.
REQ-008 In RUN with taken=1: pc_sel=1 and flush=1 in the same cycle, issue=0, stall=0; next state FLUSH with counter loaded to FLUSH_CYCLES-1.
REQ-009 In FLUSH: issue=0, stall=0, flush=1, pc_sel=0; the counter SHALL decrement each cycle and the state SHALL return to RUN on the cycle after the counter reaches 0.
REQ-010 With FLUSH_CYCLES=1, FLUSH SHALL last exactly one cycle.
REQ-011 taken while in FLUSH SHALL be ignored (bubbles contain no branches).
REQ-012 On issue & dec_needs_wb & dec_rd≠0, busy[dec_rd] SHALL be set at the next edge.
REQ-013 On wb_valid, busy[wb_addr] SHALL be cleared at the next edge.
REQ-014 Set and clear of the same bit in the same cycle: set SHALL win.
REQ-015 A clear SHALL NOT bypass into the same-cycle hazard check: a dependent instruction issues no earlier than the cycle after wb_valid.
REQ-016 busy[0] SHALL remain 0 (R0 is never tracked); wb_valid with wb_addr=0 is a no-op.
REQ-017 stall and issue SHALL be mutually exclusive; flush=1 SHALL imply issue=0.
REQ-018 busy_mask SHALL be a direct register output; all other outputs are combinational from state, counter, busy_mask and inputs.

Reset
REQ-019 While rst_n=0: state=RUN, counter=0, busy_mask=0. issue, stall, flush and pc_sel SHALL be 0 when dec_valid=0 and exe_is_branch=0.
REQ-020 Reset asserted mid-FLUSH SHALL abort the flush immediately (asynchronous); the first cycle after release SHALL be RUN.

Structure
REQ-021 A shared package SHALL hold the state enumeration (ST_RUN, ST_FLUSH), REG_ADDR_W=4, and the default constants NREG and FLUSH_CYCLES.
REQ-022 The scoreboard SHALL be a sub-module hz_scoreboard (set port, clear port, read port, mask output); the FSM and the issue logic remain in hazard_ctrl.

Verification
REQ-023 RAW: issue I1 with rd=3; next cycle DEC has rs1=3 → stall=1 until wb_valid/wb_addr=3; issue=1 exactly one cycle after the WB cycle.
REQ-024 Taken branch: exe_is_branch=1, exe_z_flag=1 with dec_valid=1 → same cycle pc_sel=1, flush=1, issue=0; flush stays 1 for 2 further cycles; then RUN.
REQ-025 Not-taken branch: exe_is_branch=1, exe_z_flag=0 → no flush, normal issue.
REQ-026 Same-cycle set/clear: issue rd=5 while wb_valid/wb_addr=5 → busy[5]=1 next cycle.
REQ-027 R0: issue rd=0 needs_wb=1, then rs1=0 reader → no stall, busy_mask stays 0.
REQ-028 Reset mid-FLUSH: assert rst_n=0 during the second FLUSH cycle → busy_mask=0 and flush=0 immediately; after release, issue resumes with no residual flush.
